// File: rtl/ob_pkg.sv
// Shared order-book types: quantities and the matcher's registered trade decision.
package ob_pkg;

  localparam int unsigned QTY_W = 16;

  typedef logic [QTY_W-1:0] quantity_t;

  typedef enum logic [1:0] {
    MK_ASK_LM_BID = 2'd0,
    LM_ASK_MK_BID = 2'd1,
    MK_ASK_MK_BID = 2'd2
  } match_kind_t;

  typedef struct packed {
    match_kind_t kind;
    logic        ask_consumed;
    logic        bid_consumed;
    quantity_t   quantity;
    quantity_t   remainder;
  } search_result_t;

endpackage

// File: rtl/ob_cntrl_mk_seq.sv
// Match-sweep sequencer: query, capture, emit and retire trades until empty, limit or stop.
module ob_cntrl_mk_seq
  import ob_pkg::*;
#(
  parameter int unsigned MAX_TRADES    = 16,
  parameter int unsigned SETTLE_CYCLES = 2
) (
  input  logic                                clk,
  input  logic                                rst_n,
  input  logic                                start,
  input  logic                                stop,
  output logic                                busy,
  output logic                                trade_qry,
  input  logic                                trade_vld_r,
  input  search_result_t                      trade_r,
  output logic                                trade_out_vld,
  input  logic                                trade_out_rdy,
  output search_result_t                      trade_out_r,
  output logic                                lm_bid_pop,
  output logic                                lm_ask_pop,
  output logic                                mk_bid_pop,
  output logic                                mk_ask_pop,
  output logic                                lm_bid_upd,
  output logic                                lm_ask_upd,
  output logic                                mk_bid_upd,
  output logic                                mk_ask_upd,
  output quantity_t                           upd_quantity,
  output logic                                done,
  output logic [$clog2(MAX_TRADES+1)-1:0]     done_cnt,
  output logic [1:0]                          done_reason
);

  localparam int unsigned CNT_W = $clog2(MAX_TRADES + 1);
  localparam int unsigned SET_W = $clog2(SETTLE_CYCLES + 1);

  localparam logic [1:0] REASON_EMPTY = 2'd0;
  localparam logic [1:0] REASON_LIMIT = 2'd1;
  localparam logic [1:0] REASON_STOP  = 2'd2;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    QRY    = 3'd1,
    WAIT   = 3'd2,
    EMIT   = 3'd3,
    SETTLE = 3'd4,
    DONE   = 3'd5
  } state_t;

  state_t         state, state_nxt;
  logic [CNT_W-1:0] trade_cnt, trade_cnt_nxt;
  logic [SET_W-1:0] settle_cnt, settle_cnt_nxt;
  logic           stop_r, stop_nxt;
  search_result_t hold, hold_nxt;
  logic [CNT_W-1:0] done_cnt_nxt;
  logic [1:0]     done_reason_nxt;
  logic           accept;
  logic           ask_mk, bid_lm, ask_upd, bid_upd;

  // State and datapath registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= IDLE;
      trade_cnt   <= '0;
      settle_cnt  <= '0;
      stop_r      <= 1'b0;
      hold        <= '0;
      done_cnt    <= '0;
      done_reason <= '0;
    end else begin
      state       <= state_nxt;
      trade_cnt   <= trade_cnt_nxt;
      settle_cnt  <= settle_cnt_nxt;
      stop_r      <= stop_nxt;
      hold        <= hold_nxt;
      done_cnt    <= done_cnt_nxt;
      done_reason <= done_reason_nxt;
    end
  end

  assign accept = (state == EMIT) && trade_out_rdy;

  // Next-state logic
  always_comb begin
    state_nxt       = state;
    trade_cnt_nxt   = trade_cnt;
    settle_cnt_nxt  = settle_cnt;
    stop_nxt        = stop_r;
    hold_nxt        = hold;
    done_cnt_nxt    = done_cnt;
    done_reason_nxt = done_reason;

    if ((state != IDLE) && stop) stop_nxt = 1'b1;

    case (state)
      IDLE: begin
        stop_nxt = 1'b0;
        if (start) begin
          state_nxt     = QRY;
          trade_cnt_nxt = '0;
        end
      end
      QRY: state_nxt = WAIT;
      WAIT: begin
        if (trade_vld_r) begin
          hold_nxt  = trade_r;
          state_nxt = EMIT;
        end else begin
          state_nxt       = DONE;
          done_cnt_nxt    = trade_cnt;
          done_reason_nxt = REASON_EMPTY;
        end
      end
      EMIT: begin
        if (accept) begin
          trade_cnt_nxt  = trade_cnt + CNT_W'(1);
          settle_cnt_nxt = SET_W'(SETTLE_CYCLES);
          state_nxt      = SETTLE;
        end
      end
      SETTLE: begin
        settle_cnt_nxt = settle_cnt - SET_W'(1);
        if (settle_cnt == SET_W'(1)) begin
          if (trade_cnt == CNT_W'(MAX_TRADES)) begin
            state_nxt       = DONE;
            done_cnt_nxt    = trade_cnt;
            done_reason_nxt = REASON_LIMIT;
          end else if (stop_r) begin
            state_nxt       = DONE;
            done_cnt_nxt    = trade_cnt;
            done_reason_nxt = REASON_STOP;
          end else begin
            state_nxt = QRY;
          end
        end
      end
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Side decode: a malformed "neither consumed" trade updates only the ask side
  always_comb begin
    ask_mk       = 1'b0;
    bid_lm       = 1'b0;
    ask_upd      = 1'b0;
    bid_upd      = 1'b0;
    lm_bid_pop   = 1'b0;
    lm_ask_pop   = 1'b0;
    mk_bid_pop   = 1'b0;
    mk_ask_pop   = 1'b0;
    lm_bid_upd   = 1'b0;
    lm_ask_upd   = 1'b0;
    mk_bid_upd   = 1'b0;
    mk_ask_upd   = 1'b0;
    upd_quantity = '0;
    if (accept) begin
      ask_mk     = (hold.kind != LM_ASK_MK_BID);
      bid_lm     = (hold.kind == MK_ASK_LM_BID);
      ask_upd    = !hold.ask_consumed;
      bid_upd    = !hold.bid_consumed && hold.ask_consumed;
      mk_ask_pop = ask_mk && hold.ask_consumed;
      lm_ask_pop = !ask_mk && hold.ask_consumed;
      mk_bid_pop = !bid_lm && hold.bid_consumed;
      lm_bid_pop = bid_lm && hold.bid_consumed;
      mk_ask_upd = ask_mk && ask_upd;
      lm_ask_upd = !ask_mk && ask_upd;
      mk_bid_upd = !bid_lm && bid_upd;
      lm_bid_upd = bid_lm && bid_upd;
      if (ask_upd || bid_upd) upd_quantity = hold.remainder;
    end
  end

  assign busy          = (state != IDLE);
  assign trade_qry     = (state == QRY);
  assign trade_out_vld = (state == EMIT);
  assign trade_out_r   = hold;
  assign done          = (state == DONE);

endmodule

// File: tb/tb_ob_cntrl_mk_seq.sv
// Directed bench for ob_cntrl_mk_seq: vector table of side mappings plus sweep-level sequences.
module tb_ob_cntrl_mk_seq;
  import ob_pkg::*;

  logic           clk = 1'b0;
  logic           rst_n = 1'b0;
  logic           start = 1'b0;
  logic           stop = 1'b0;
  logic           busy, trade_qry, trade_out_vld, done;
  logic           trade_vld_r;
  search_result_t trade_r = '0;
  logic           trade_out_rdy = 1'b0;
  search_result_t trade_out_r;
  logic           lm_bid_pop, lm_ask_pop, mk_bid_pop, mk_ask_pop;
  logic           lm_bid_upd, lm_ask_upd, mk_bid_upd, mk_ask_upd;
  quantity_t      upd_quantity;
  logic [1:0]     done_cnt;
  logic [1:0]     done_reason;
  logic           match_on = 1'b0;
  logic [7:0]     strobes;

  int total = 0;
  int bad   = 0;

  ob_cntrl_mk_seq #(.MAX_TRADES(3), .SETTLE_CYCLES(2)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .stop(stop), .busy(busy),
    .trade_qry(trade_qry), .trade_vld_r(trade_vld_r), .trade_r(trade_r),
    .trade_out_vld(trade_out_vld), .trade_out_rdy(trade_out_rdy), .trade_out_r(trade_out_r),
    .lm_bid_pop(lm_bid_pop), .lm_ask_pop(lm_ask_pop), .mk_bid_pop(mk_bid_pop), .mk_ask_pop(mk_ask_pop),
    .lm_bid_upd(lm_bid_upd), .lm_ask_upd(lm_ask_upd), .mk_bid_upd(mk_bid_upd), .mk_ask_upd(mk_ask_upd),
    .upd_quantity(upd_quantity), .done(done), .done_cnt(done_cnt), .done_reason(done_reason)
  );

  always #5 clk = ~clk;

  // Matcher stand-in: registered answer one cycle after each query
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) trade_vld_r <= 1'b0;
    else        trade_vld_r <= trade_qry & match_on;
  end

  assign strobes = {lm_bid_pop, lm_ask_pop, mk_bid_pop, mk_ask_pop,
                    lm_bid_upd, lm_ask_upd, mk_bid_upd, mk_ask_upd};

  typedef struct {
    search_result_t res;
    logic [7:0]     exp_strb;
    quantity_t      exp_q;
  } vec_t;

  vec_t vecs[6];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", name, act, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  function automatic search_result_t mk(input match_kind_t k, input logic ac, input logic bc,
                                        input int unsigned rem);
    search_result_t r;
    r.kind         = k;
    r.ask_consumed = ac;
    r.bid_consumed = bc;
    r.quantity     = 16'd60;
    r.remainder    = 16'(rem);
    return r;
  endfunction

  // One-trade sweep: trade accepted in cycle 3, empty query afterwards, done in cycle 8
  task automatic run_one(input vec_t v, input string tag);
    trade_r = v.res; match_on = 1'b1; trade_out_rdy = 1'b1; start = 1'b1;
    tick(1);
    chk({tag, ".qry"}, 64'(trade_qry), 64'd1);
    start = 1'b0;
    tick(1);
    chk({tag, ".wait_busy"}, 64'(busy), 64'd1);
    chk({tag, ".wait_vld"}, 64'(trade_out_vld), 64'd0);
    tick(1);
    chk({tag, ".emit_vld"}, 64'(trade_out_vld), 64'd1);
    chk({tag, ".emit_data"}, 64'(trade_out_r), 64'(v.res));
    chk({tag, ".strobes"}, 64'(strobes), 64'(v.exp_strb));
    chk({tag, ".upd_q"}, 64'(upd_quantity), 64'(v.exp_q));
    match_on = 1'b0;
    tick(1);
    chk({tag, ".settle_strb"}, 64'(strobes), 64'd0);
    tick(4);
    chk({tag, ".done"}, 64'(done), 64'd1);
    chk({tag, ".done_cnt"}, 64'(done_cnt), 64'd1);
    chk({tag, ".reason"}, 64'(done_reason), 64'd0);
    tick(1);
    chk({tag, ".idle"}, 64'(busy), 64'd0);
  endtask

  initial begin
    int n_acc, n_qry, done_at;
    int acc_at[4];
    bit got_done;
    search_result_t exp_r;

    vecs[0] = '{mk(MK_ASK_LM_BID, 1'b1, 1'b0, 40),  8'b0001_1000, 16'd40};
    vecs[1] = '{mk(MK_ASK_MK_BID, 1'b1, 1'b1, 33),  8'b0011_0000, 16'd0};
    vecs[2] = '{mk(LM_ASK_MK_BID, 1'b0, 1'b1, 25),  8'b0010_0100, 16'd25};
    vecs[3] = '{mk(LM_ASK_MK_BID, 1'b1, 1'b1, 5),   8'b0110_0000, 16'd0};
    vecs[4] = '{mk(MK_ASK_LM_BID, 1'b0, 1'b1, 7),   8'b1000_0001, 16'd7};
    vecs[5] = '{mk(MK_ASK_MK_BID, 1'b1, 1'b0, 100), 8'b0001_0010, 16'd100};

    // Reset values
    #2;
    chk("rst.busy", 64'(busy), 64'd0);
    chk("rst.qry", 64'(trade_qry), 64'd0);
    chk("rst.out_r", 64'(trade_out_r), 64'd0);
    chk("rst.done", 64'({done, done_cnt, done_reason}), 64'd0);
    chk("rst.strb", 64'({strobes, upd_quantity}), 64'd0);
    tick(2);
    rst_n = 1'b1;
    tick(1);

    // Empty book
    match_on = 1'b0; start = 1'b1;
    tick(1);
    chk("empty.qry", 64'(trade_qry), 64'd1);
    start = 1'b0;
    tick(1);
    chk("empty.busy", 64'(busy), 64'd1);
    chk("empty.strb2", 64'(strobes), 64'd0);
    tick(1);
    chk("empty.done", 64'(done), 64'd1);
    chk("empty.cnt", 64'(done_cnt), 64'd0);
    chk("empty.reason", 64'(done_reason), 64'd0);
    chk("empty.strb3", 64'(strobes), 64'd0);
    tick(1);
    chk("empty.idle", 64'({busy, done}), 64'd0);

    // Side-mapping table
    for (int i = 0; i < 6; i++) begin
      run_one(vecs[i], $sformatf("vec%0d", i));
      tick(1);
    end

    // Limit: matcher always trades, MAX_TRADES=3
    trade_r = mk(MK_ASK_MK_BID, 1'b1, 1'b1, 0);
    match_on = 1'b1; trade_out_rdy = 1'b1; start = 1'b1;
    n_acc = 0; n_qry = 0; got_done = 1'b0; done_at = 0;
    for (int c = 1; c <= 40 && !got_done; c++) begin
      tick(1);
      if (c == 1) start = 1'b0;
      if (trade_qry) n_qry++;
      if (trade_out_vld && trade_out_rdy) begin
        if (n_acc < 4) acc_at[n_acc] = c;
        n_acc++;
      end
      if (done) begin
        got_done = 1'b1;
        done_at  = c;
        chk("limit.cnt", 64'(done_cnt), 64'd3);
        chk("limit.reason", 64'(done_reason), 64'd1);
      end
    end
    chk("limit.got_done", 64'(got_done), 64'd1);
    chk("limit.n_acc", 64'(n_acc), 64'd3);
    chk("limit.acc0", 64'(acc_at[0]), 64'd3);
    chk("limit.acc1", 64'(acc_at[1]), 64'd8);
    chk("limit.acc2", 64'(acc_at[2]), 64'd13);
    chk("limit.done_at", 64'(done_at), 64'd16);
    chk("limit.n_qry", 64'(n_qry), 64'd3);
    n_qry = 0;
    for (int c = 0; c < 6; c++) begin
      tick(1);
      if (trade_qry) n_qry++;
    end
    chk("limit.no_4th_qry", 64'(n_qry), 64'd0);
    chk("limit.idle", 64'(busy), 64'd0);
    match_on = 1'b0;

    // Backpressure with stop during EMIT
    exp_r = mk(LM_ASK_MK_BID, 1'b1, 1'b0, 9);
    trade_r = exp_r; match_on = 1'b1; trade_out_rdy = 1'b0; start = 1'b1;
    tick(1);
    start = 1'b0;
    tick(2);
    stop = 1'b1;
    for (int i = 0; i < 10; i++) begin
      chk($sformatf("bp.vld%0d", i), 64'(trade_out_vld), 64'd1);
      chk($sformatf("bp.data%0d", i), 64'(trade_out_r), 64'(exp_r));
      chk($sformatf("bp.strb%0d", i), 64'(strobes), 64'd0);
      tick(1);
      stop = 1'b0;
    end
    match_on = 1'b0;
    trade_out_rdy = 1'b1;
    #1;
    chk("bp.accept_strb", 64'(strobes), 64'b0100_0010);
    chk("bp.accept_q", 64'(upd_quantity), 64'd9);
    tick(3);
    chk("bp.done", 64'(done), 64'd1);
    chk("bp.reason", 64'(done_reason), 64'd2);
    chk("bp.cnt", 64'(done_cnt), 64'd1);
    tick(2);

    // Reset during SETTLE, then a fresh sweep
    trade_r = vecs[0].res; match_on = 1'b1; trade_out_rdy = 1'b1; start = 1'b1;
    tick(1);
    start = 1'b0;
    tick(3);
    chk("rmid.settle_busy", 64'(busy), 64'd1);
    #1 rst_n = 1'b0;
    #1;
    chk("rmid.busy", 64'(busy), 64'd0);
    chk("rmid.out_r", 64'(trade_out_r), 64'd0);
    chk("rmid.done", 64'({done, done_cnt, done_reason}), 64'd0);
    chk("rmid.strb", 64'({strobes, upd_quantity, trade_qry, trade_out_vld}), 64'd0);
    match_on = 1'b0;
    tick(1);
    chk("rmid.hold_done", 64'(done), 64'd0);
    tick(1);
    rst_n = 1'b1;
    tick(1);
    chk("rmid.after_done", 64'(done), 64'd0);
    run_one(vecs[0], "fresh");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1, "watchdog");
  end

endmodule
